// File: rtl/l1_mau_resp_pkg.sv
// Shared geometry and state encoding for the L1-to-MAU responder.
package l1_mau_resp_pkg;

    localparam int unsigned L1_LINE_SIZE   = 256;
    localparam int unsigned ADDR_WIDTH     = 32;
    localparam int unsigned MEM_DATA_WIDTH = 32;
    localparam int unsigned BEATS          = L1_LINE_SIZE / MEM_DATA_WIDTH;
    localparam int unsigned OFFS           = $clog2(L1_LINE_SIZE / 8);
    localparam int unsigned BEAT_IDX_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned CNT_W          = $clog2(BEATS + 1);

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StRdnc,
        StWrite,
        StAck
    } mau_state_e;

endpackage

// File: rtl/l1_mau_linebuf.sv
// Line buffer: word-indexed register file with a top-word write port and a flat read.
module l1_mau_linebuf
    import l1_mau_resp_pkg::*;
#(
    parameter int unsigned Beats = BEATS,
    parameter int unsigned WordW = MEM_DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [BEAT_IDX_W-1:0]  wr_idx,
    input  logic [WordW-1:0]       wr_data,
    input  logic                   top_en,
    input  logic [WordW-1:0]       top_data,
    output logic [Beats*WordW-1:0] rd_line
);

    logic [Beats-1:0][WordW-1:0] words_q, words_d;

    always_comb begin
        words_d = words_q;
        if (wr_en) begin
            words_d[wr_idx] = wr_data;
        end
        if (top_en) begin
            words_d[Beats-1] = top_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_q <= '0;
        end else begin
            words_q <= words_d;
        end
    end

    assign rd_line = words_q;

endmodule

// File: rtl/l1_mau_resp.sv
// L1-to-MAU responder: runs fills, non-cacheable reads and writes on a word-wide memory bus
// and returns a single-cycle ack carrying the line buffer.
module l1_mau_resp
    import l1_mau_resp_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mau_req_val,
    input  logic                      mau_req_nc,
    input  logic                      mau_req_we,
    input  logic [ADDR_WIDTH-1:0]     mau_req_addr,
    input  logic [MEM_DATA_WIDTH-1:0] mau_req_wdata,
    input  logic [3:0]                mau_req_be,
    output logic                      mau_req_ack,
    output logic                      mau_ack_nc,
    output logic                      mau_ack_we,
    output logic [L1_LINE_SIZE-1:0]   mau_ack_data,
    output logic                      mem_req_val,
    output logic                      mem_req_we,
    output logic [ADDR_WIDTH-1:0]     mem_req_addr,
    output logic [MEM_DATA_WIDTH-1:0] mem_req_wdata,
    output logic [3:0]                mem_req_be,
    input  logic                      mem_req_ack,
    input  logic                      mem_rsp_val,
    input  logic [MEM_DATA_WIDTH-1:0] mem_rsp_data
);

    mau_state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [MEM_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]                be_q, be_d;
    logic                      nc_q, nc_d;
    logic                      we_q, we_d;
    logic [CNT_W-1:0]          ic_q, ic_d;
    logic [CNT_W-1:0]          rc_q, rc_d;

    logic                      lb_wr_en;
    logic                      lb_top_en;
    logic [ADDR_WIDTH-1:0]     fill_addr;
    logic [ADDR_WIDTH-1:0]     word_addr;
    logic [1:0]                byte_off;

    assign byte_off  = addr_q[1:0];
    assign word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign fill_addr = {addr_q[ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}}
                     + ADDR_WIDTH'({ic_q, 2'b00});

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        be_d          = be_q;
        nc_d          = nc_q;
        we_d          = we_q;
        ic_d          = ic_q;
        rc_d          = rc_q;
        lb_wr_en      = 1'b0;
        lb_top_en     = 1'b0;
        mem_req_val   = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        mem_req_be    = '0;
        mau_req_ack   = 1'b0;
        mau_ack_nc    = 1'b0;
        mau_ack_we    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (mau_req_val) begin
                    addr_d  = mau_req_addr;
                    wdata_d = mau_req_wdata;
                    be_d    = mau_req_be;
                    nc_d    = mau_req_nc;
                    we_d    = mau_req_we;
                    ic_d    = '0;
                    rc_d    = '0;
                    if (mau_req_we) begin
                        state_d = StWrite;
                    end else if (mau_req_nc) begin
                        state_d = StRdnc;
                    end else begin
                        state_d = StFill;
                    end
                end
            end
            StFill: begin
                // Issue and receive run independently so accepts and responses may overlap.
                if (ic_q < CNT_W'(BEATS)) begin
                    mem_req_val  = 1'b1;
                    mem_req_addr = fill_addr;
                    if (mem_req_ack) begin
                        ic_d = ic_q + 1'b1;
                    end
                end
                if (mem_rsp_val) begin
                    lb_wr_en = 1'b1;
                    rc_d     = rc_q + 1'b1;
                    if (rc_q == CNT_W'(BEATS - 1)) begin
                        state_d = StAck;
                    end
                end
            end
            StRdnc: begin
                if (ic_q == '0) begin
                    mem_req_val  = 1'b1;
                    mem_req_addr = word_addr;
                    if (mem_req_ack) begin
                        ic_d = CNT_W'(1);
                    end
                end
                if (mem_rsp_val) begin
                    lb_top_en = 1'b1;
                    state_d   = StAck;
                end
            end
            StWrite: begin
                mem_req_val   = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = word_addr;
                mem_req_wdata = wdata_q << {byte_off, 3'b000};
                mem_req_be    = be_q << byte_off;
                if (mem_req_ack) begin
                    state_d = StAck;
                end
            end
            StAck: begin
                // The held request is not sampled here, so it cannot be captured twice.
                mau_req_ack = 1'b1;
                mau_ack_nc  = nc_q;
                mau_ack_we  = we_q;
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            nc_q    <= 1'b0;
            we_q    <= 1'b0;
            ic_q    <= '0;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            nc_q    <= nc_d;
            we_q    <= we_d;
            ic_q    <= ic_d;
            rc_q    <= rc_d;
        end
    end

    l1_mau_linebuf #(
        .Beats (BEATS),
        .WordW (MEM_DATA_WIDTH)
    ) u_linebuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (lb_wr_en),
        .wr_idx   (rc_q[BEAT_IDX_W-1:0]),
        .wr_data  (mem_rsp_data),
        .top_en   (lb_top_en),
        .top_data (mem_rsp_data),
        .rd_line  (mau_ack_data)
    );

    a_rsp_in_read: assert property (@(posedge clk) disable iff (!rst_n)
        mem_rsp_val |-> (state_q inside {StFill, StRdnc}));

    a_rc_le_ic: assert property (@(posedge clk) disable iff (!rst_n)
        rc_q <= ic_q);

    a_be_legal: assert property (@(posedge clk) disable iff (!rst_n)
        mau_req_val |-> (mau_req_be inside {4'b0001, 4'b0011, 4'b1111}));

endmodule
